// File: rtl/if_axis_rx_fifo_if.sv
// Bus and AXI-Stream signal bundle for the stream receive FIFO peripheral.
// The slave modport is the peripheral's view; master is the CPU/stream-source view.
interface if_axis_rx_fifo_if #(
  parameter int AXIS_DATA_WIDTH = 8
) ();
  logic [31:0]                addr_i;
  logic [31:0]                data_i;
  logic                       data_w_i;
  logic                       data_r_i;
  logic [31:0]                data_o;
  logic                       data_access_o;
  logic                       s_axis_tvalid_i;
  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata_i;
  logic                       s_axis_tlast_i;
  logic                       s_axis_tready_o;

  modport slave (
    input  addr_i, data_i, data_w_i, data_r_i,
    input  s_axis_tvalid_i, s_axis_tdata_i, s_axis_tlast_i,
    output data_o, data_access_o, s_axis_tready_o
  );

  modport master (
    output addr_i, data_i, data_w_i, data_r_i,
    output s_axis_tvalid_i, s_axis_tdata_i, s_axis_tlast_i,
    input  data_o, data_access_o, s_axis_tready_o
  );
endinterface

// File: rtl/if_axis_rx_fifo.sv
// Memory-mapped AXI-Stream receive peripheral: buffers {tlast, tdata} beats in a
// power-of-two FIFO that software drains through STATUS/DATA/CONTROL registers.
module if_axis_rx_fifo #(
  parameter logic [7:0] SOC_SEGMENT     = 8'hE4,
  parameter logic [7:0] SOC_CLASS       = 8'hA9,
  parameter int         AXIS_DATA_WIDTH = 8,
  parameter int         FIFO_DEPTH_LOG2 = 4
) (
  input  logic               axis_aclk_i,
  input  logic               axis_aresetn_i,
  if_axis_rx_fifo_if.slave   bus
);
  localparam int W     = AXIS_DATA_WIDTH;
  localparam int N     = FIFO_DEPTH_LOG2;
  localparam int DEPTH = 1 << N;

  localparam logic [2:0] SEL_STATUS  = 3'b001;
  localparam logic [2:0] SEL_DATA    = 3'b010;
  localparam logic [2:0] SEL_CONTROL = 3'b011;

  localparam logic [N-1:0] PTR_ONE  = 1;
  localparam logic [N:0]   CNT_ONE  = 1;
  localparam logic [N:0]   CNT_FULL = {1'b1, {N{1'b0}}};

  logic [W:0]   mem_q [DEPTH];
  logic [N-1:0] wr_ptr_q, wr_ptr_d;
  logic [N-1:0] rd_ptr_q, rd_ptr_d;
  logic [N:0]   count_q, count_d;
  logic         enable_q, enable_d;
  logic         drop_mode_q, drop_mode_d;
  logic         overflow_q, overflow_d;
  logic [31:0]  data_o_q, data_o_d;

  logic         access, rd_en, ctrl_wr, flush, ovf_clr;
  logic         empty, full, tready, beat, push, pop, mem_we;
  logic [2:0]   sel;
  logic [W:0]   head;
  logic [31:0]  status_word, data_word, ctrl_word;
  logic         unused_bits;

  assign access  = (bus.addr_i[31:24] == SOC_SEGMENT) && (bus.addr_i[23:16] == SOC_CLASS);
  assign sel     = bus.addr_i[6:4];
  assign rd_en   = access && bus.data_r_i;
  assign ctrl_wr = access && bus.data_w_i && (sel == SEL_CONTROL);
  assign flush   = ctrl_wr && bus.data_i[1];
  assign ovf_clr = ctrl_wr && bus.data_i[2];

  assign empty  = (count_q == '0);
  assign full   = (count_q == CNT_FULL);
  assign tready = enable_q && (drop_mode_q || !full);
  assign beat   = bus.s_axis_tvalid_i && tready;
  assign push   = beat && !full;
  assign pop    = rd_en && (sel == SEL_DATA) && !empty;
  assign mem_we = push && !flush;
  assign head   = mem_q[rd_ptr_q];

  assign bus.data_access_o   = access;
  assign bus.s_axis_tready_o = tready;
  assign bus.data_o          = data_o_q;

  assign unused_bits = ^{bus.addr_i[15:7], bus.addr_i[3:0], bus.data_i[31:4]};

  always_comb begin
    status_word        = '0;
    status_word[31:16] = 16'(count_q);
    status_word[3]     = !empty && head[W];
    status_word[2]     = overflow_q;
    status_word[1]     = full;
    status_word[0]     = !empty;

    data_word = '0;
    if (!empty) begin
      data_word[W-1:0] = head[W-1:0];
      data_word[31]    = head[W];
    end

    ctrl_word = {28'b0, drop_mode_q, 2'b00, enable_q};
  end

  // Reads see pre-update state, so a pop in a flush cycle still returns the old head.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    enable_d    = enable_q;
    drop_mode_d = drop_mode_q;
    overflow_d  = overflow_q;
    data_o_d    = data_o_q;

    if (rd_en) begin
      unique case (sel)
        SEL_STATUS:  data_o_d = status_word;
        SEL_DATA:    data_o_d = data_word;
        SEL_CONTROL: data_o_d = ctrl_word;
        default:     data_o_d = '0;
      endcase
    end

    if (ctrl_wr) begin
      enable_d    = bus.data_i[0];
      drop_mode_d = bus.data_i[3];
    end

    if (beat && full) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge axis_aclk_i or negedge axis_aresetn_i) begin
    if (!axis_aresetn_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      enable_q    <= 1'b0;
      drop_mode_q <= 1'b0;
      overflow_q  <= 1'b0;
      data_o_q    <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      enable_q    <= enable_d;
      drop_mode_q <= drop_mode_d;
      overflow_q  <= overflow_d;
      data_o_q    <= data_o_d;
    end
  end

  // Storage needs no reset: only entries below count are ever observable.
  always_ff @(posedge axis_aclk_i) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= {bus.s_axis_tlast_i, bus.s_axis_tdata_i};
    end
  end
endmodule
